isbox_ctrl: RTL and testbench

Row sequencer for the inverse S-box array. It accepts a 16x16 character-matrix job and a row-select mask from the decryption datapath. It then drives the shared isbox one row at a time through its one-hot row mask and captures each returned row into an output buffer. Rows not selected pass through unchanged. It pulses done, and flags an error if the isbox fails to answer.

---
 rtl/isbox_ctrl_pkg.sv | 20 ++
 rtl/isbox_row_pick.sv | 22 ++
 rtl/isbox_ctrl.sv | 120 ++++++++++++
 tb/tb_isbox_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/isbox_ctrl_pkg.sv
// Shared types and sizing for the inverse S-box row sequencer.
package isbox_ctrl_pkg;

  localparam int ROW_CNT   = 16;
  localparam int CHAR_W    = 16;
  localparam int ROW_IDX_W = $clog2(ROW_CNT);

  typedef logic [CHAR_W-1:0]  char_t;
  typedef char_t [ROW_CNT-1:0] char_row_t;
  typedef char_row_t [ROW_CNT-1:0] char_matrix_t;
  typedef logic [ROW_CNT-1:0] row_mask_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } ctrl_state_e;

endpackage

// File: rtl/isbox_row_pick.sv
// Lowest-set-bit encoder: picks the next row still pending substitution.
module isbox_row_pick
  import isbox_ctrl_pkg::*;
(
  input  row_mask_t              i_bits,
  output logic [ROW_IDX_W-1:0]   o_idx,
  output logic                   o_none
);

  // Scan high to low so the last hit is the lowest set bit.
  always_comb begin
    o_idx  = '0;
    o_none = 1'b1;
    for (int r = ROW_CNT - 1; r >= 0; r--) begin
      if (i_bits[r]) begin
        o_idx  = ROW_IDX_W'(r);
        o_none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/isbox_ctrl.sv
// Row sequencer: walks the selected rows through the shared isbox one at a
// time and assembles the substituted rows into a held result buffer.
module isbox_ctrl
  import isbox_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         ctrl_ip_start,
  input  row_mask_t    ctrl_ip_row_mask,
  input  char_matrix_t ctrl_ip_char_matrix,
  output logic         ctrl_op_busy,
  output logic         ctrl_op_done,
  output logic         ctrl_op_timeout_err,
  output char_matrix_t ctrl_op_char_matrix,
  output char_matrix_t isbox_ip_char_matrix,
  output row_mask_t    isbox_ip_char_row_mask,
  input  logic         isbox_op_char_matrix_valid,
  input  char_matrix_t isbox_op_char_matrix
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  ctrl_state_e            r_state;
  ctrl_state_e            w_next;
  char_matrix_t           r_job;
  char_matrix_t           r_buf;
  row_mask_t              r_remaining;
  logic [ROW_IDX_W-1:0]   r_cur_row;
  logic [7:0]             r_cnt;
  logic                   r_err;

  logic [ROW_IDX_W-1:0]   w_pick_idx;
  logic                   w_pick_none;
  row_mask_t              w_cur_onehot;
  row_mask_t              w_rem_after;
  logic                   w_timeout_hit;

  isbox_row_pick u_row_pick (
    .i_bits (r_remaining),
    .o_idx  (w_pick_idx),
    .o_none (w_pick_none)
  );

  assign w_cur_onehot  = row_mask_t'(1) << r_cur_row;
  assign w_rem_after   = r_remaining & ~w_cur_onehot;
  assign w_timeout_hit = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (ctrl_ip_start)
          w_next = (ctrl_ip_row_mask == '0) ? DONE : ISSUE;
      end
      // An empty pending set here cannot happen in normal flow; finish cleanly.
      ISSUE: w_next = w_pick_none ? DONE : WAIT;
      WAIT: begin
        if (isbox_op_char_matrix_valid)
          w_next = (w_rem_after == '0) ? DONE : ISSUE;
        else if (w_timeout_hit)
          w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_job       <= '0;
      r_buf       <= '0;
      r_remaining <= '0;
      r_cur_row   <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ctrl_ip_start) begin
            r_job       <= ctrl_ip_char_matrix;
            r_buf       <= ctrl_ip_char_matrix;
            r_remaining <= ctrl_ip_row_mask;
            r_err       <= 1'b0;
          end
        end
        ISSUE: begin
          r_cur_row <= w_pick_idx;
          r_cnt     <= '0;
        end
        WAIT: begin
          if (isbox_op_char_matrix_valid) begin
            r_buf[r_cur_row] <= isbox_op_char_matrix[r_cur_row];
            r_remaining      <= w_rem_after;
          end else if (w_timeout_hit) begin
            r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // The row mask drops to 0 outside WAIT, giving the isbox a gap between rows.
  assign isbox_ip_char_row_mask = (r_state == WAIT) ? w_cur_onehot : '0;
  assign isbox_ip_char_matrix   = r_job;
  assign ctrl_op_char_matrix    = r_buf;
  assign ctrl_op_busy           = (r_state != IDLE);
  assign ctrl_op_done           = (r_state == DONE);
  assign ctrl_op_timeout_err    = r_err;

endmodule

// File: tb/tb_isbox_ctrl.sv
// Directed bench for isbox_ctrl with a stub isbox and a per-cycle row-mask scoreboard.
module tb_isbox_ctrl;
  import isbox_ctrl_pkg::*;

  localparam int TMO = 8;

  logic         clk;
  logic         resetn;
  logic         start;
  row_mask_t    mask_in;
  char_matrix_t in_mat;
  logic         busy;
  logic         done;
  logic         err;
  char_matrix_t out_mat;
  char_matrix_t job_mat;
  row_mask_t    row_mask;
  logic         isb_valid;
  char_matrix_t isb_out;
  logic         stub_en;

  int checks;
  int errors;

  row_mask_t    exp_mask_q[$];
  char_matrix_t exp_mat;
  logic         exp_err;

  isbox_ctrl #(.TIMEOUT(TMO)) dut (
    .clk                        (clk),
    .resetn                     (resetn),
    .ctrl_ip_start              (start),
    .ctrl_ip_row_mask           (mask_in),
    .ctrl_ip_char_matrix        (in_mat),
    .ctrl_op_busy               (busy),
    .ctrl_op_done               (done),
    .ctrl_op_timeout_err        (err),
    .ctrl_op_char_matrix        (out_mat),
    .isbox_ip_char_matrix       (job_mat),
    .isbox_ip_char_row_mask     (row_mask),
    .isbox_op_char_matrix_valid (isb_valid),
    .isbox_op_char_matrix       (isb_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub isbox: answers immediately on the selected row, junk elsewhere.
  always_comb begin
    isb_valid = stub_en & (|row_mask);
    for (int i = 0; i < ROW_CNT; i++)
      for (int j = 0; j < ROW_CNT; j++)
        isb_out[i][j] = row_mask[i] ? (job_mat[i][j] ^ 16'hFFFF) : 16'hDEAD;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build_expect(input row_mask_t m, input bit vld);
    int low;
    exp_mask_q.delete();
    low = -1;
    if (m != '0) begin
      if (vld) begin
        for (int r = 0; r < ROW_CNT; r++)
          if (m[r]) begin
            exp_mask_q.push_back('0);
            exp_mask_q.push_back(row_mask_t'(1) << r);
          end
      end else begin
        for (int r = ROW_CNT - 1; r >= 0; r--)
          if (m[r]) low = r;
        exp_mask_q.push_back('0);
        for (int t = 0; t < TMO; t++)
          exp_mask_q.push_back(row_mask_t'(1) << low);
      end
    end
    exp_mask_q.push_back('0);
    for (int i = 0; i < ROW_CNT; i++)
      for (int j = 0; j < ROW_CNT; j++)
        exp_mat[i][j] = (vld && m[i]) ? (in_mat[i][j] ^ 16'hFFFF) : in_mat[i][j];
    exp_err = (!vld && m != '0);
  endtask

  task automatic run_job(input string name, input row_mask_t m, input bit vld, input bit inject);
    int len;
    build_expect(m, vld);
    len = exp_mask_q.size();
    @(negedge clk);
    stub_en = vld;
    start   = 1'b1;
    mask_in = m;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= len; c++) begin
      if (inject && c == 2) begin
        start   = 1'b1;
        mask_in = 16'hFFFF;
      end
      if (inject && c == 3) start = 1'b0;
      check($sformatf("%s c%0d rowmask", name, c), 256'(row_mask), 256'(exp_mask_q.pop_front()));
      check($sformatf("%s c%0d busy", name, c), 256'(busy), 256'(1'b1));
      check($sformatf("%s c%0d done", name, c), 256'(done), 256'(c == len));
      if (c == 1)
        check($sformatf("%s jobrow3", name), 256'(job_mat[3]), 256'(in_mat[3]));
      if (c == len) begin
        check($sformatf("%s err", name), 256'(err), 256'(exp_err));
        for (int i = 0; i < ROW_CNT; i++)
          check($sformatf("%s out_row%0d", name, i), 256'(out_mat[i]), 256'(exp_mat[i]));
      end
      @(posedge clk);
      #1;
    end
    check($sformatf("%s idle busy", name), 256'(busy), 256'(1'b0));
    check($sformatf("%s idle done", name), 256'(done), 256'(1'b0));
    check($sformatf("%s idle err", name), 256'(err), 256'(exp_err));
    check($sformatf("%s idle out_row0", name), 256'(out_mat[0]), 256'(exp_mat[0]));
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    resetn  = 1'b0;
    start   = 1'b0;
    mask_in = '0;
    stub_en = 1'b1;
    for (int i = 0; i < ROW_CNT; i++)
      for (int j = 0; j < ROW_CNT; j++)
        in_mat[i][j] = 16'(10 * i + j);

    #20;
    check("rst busy", 256'(busy), 256'(1'b0));
    check("rst done", 256'(done), 256'(1'b0));
    check("rst err", 256'(err), 256'(1'b0));
    check("rst rowmask", 256'(row_mask), 256'(0));
    for (int i = 0; i < ROW_CNT; i++)
      check($sformatf("rst out_row%0d", i), 256'(out_mat[i]), 256'(0));
    @(negedge clk);
    resetn = 1'b1;

    run_job("all", 16'hFFFF, 1'b1, 1'b0);
    run_job("row0", 16'h0001, 1'b1, 1'b0);
    run_job("none", 16'h0000, 1'b1, 1'b0);
    run_job("tmo", 16'h0003, 1'b0, 1'b0);
    run_job("clr", 16'h0000, 1'b1, 1'b0);
    run_job("inj", 16'h0003, 1'b1, 1'b1);

    // Abort by reset while row 5 is stuck in WAIT.
    @(negedge clk);
    stub_en = 1'b0;
    start   = 1'b1;
    mask_in = 16'h0020;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("abort wait rowmask", 256'(row_mask), 256'(16'h0020));
    #2;
    resetn = 1'b0;
    #1;
    check("abort busy", 256'(busy), 256'(1'b0));
    check("abort done", 256'(done), 256'(1'b0));
    check("abort err", 256'(err), 256'(1'b0));
    check("abort rowmask", 256'(row_mask), 256'(0));
    for (int i = 0; i < ROW_CNT; i++) begin
      check($sformatf("abort out_row%0d", i), 256'(out_mat[i]), 256'(0));
      check($sformatf("abort job_row%0d", i), 256'(job_mat[i]), 256'(0));
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("abort hold done%0d", c), 256'(done), 256'(1'b0));
    end
    @(negedge clk);
    resetn  = 1'b1;
    stub_en = 1'b1;
    run_job("post", 16'h0001, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
